l2k_tlb_sa: RTL and testbench

//  Parametrised set-associative TLB for the Limn2600 core; next generation of the direct-mapped MMU.

---
 rtl/l2k_tlb_sa.sv | 263 ++++++++++++++++++++++++++
 tb/tb_l2k_tlb_sa.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2k_tlb_sa.sv
// Set-associative TLB: registered 1-cycle lookup, write/read/invalidate command port, per-set RR victim.
// Latency 1 for lookup and READ; commands win over lookups; sweeps stall both ports SETS cycles. Optional L2K_TLB_PERF_EN adds hit/miss counters.
// Backpressure: lk_ready drops while a command is offered or a sweep runs; cmd_ready drops only during a sweep.
module l2k_tlb_sa #(
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int ASID_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              kmode,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [31:0]       lk_vaddr,
    input  logic              lk_write,
    output logic              rs_valid,
    output logic [31:0]       rs_paddr,
    output logic              rs_miss,
    output logic              rs_prot,
    output logic              rs_nc,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_vaddr,
    input  logic [ASID_W-1:0] cmd_asid,
    input  logic [63:0]       cmd_entry,
    output logic              rd_valid,
    output logic [63:0]       rd_entry
`ifdef L2K_TLB_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);
    localparam int IDXW = $clog2(SETS);
    localparam int RRW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] OP_WRITE    = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_INV_ALL  = 2'd2;

    typedef enum logic {IDLE, SWEEP} state_e;

    // Entry layout: [63:44] VPN, [43:32] ASID, [24:5] PPN, [4] G, [3] NC, [2] K, [1] W, [0] V
    logic [63:0]                   ent_q [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d;
    logic [SETS-1:0][RRW-1:0]      rr_q, rr_d;
    state_e                        state_q, state_d;
    logic [IDXW-1:0]               sweep_idx_q, sweep_idx_d;
    logic                          sweep_all_q, sweep_all_d;
    logic [ASID_W-1:0]             sweep_asid_q, sweep_asid_d;

    logic                          rs_valid_q, rs_valid_d;
    logic [31:0]                   rs_paddr_q, rs_paddr_d;
    logic                          rs_miss_q, rs_miss_d;
    logic                          rs_prot_q, rs_prot_d;
    logic                          rs_nc_q, rs_nc_d;
    logic                          rd_valid_q, rd_valid_d;
    logic [63:0]                   rd_entry_q, rd_entry_d;

    logic                          lk_acc, cmd_acc;
    logic [IDXW-1:0]               lk_idx, cmd_idx;
    logic                          lk_hit, cmd_hit, inv_found;
    logic [63:0]                   lk_ent, cmd_ent;
    logic [RRW-1:0]                hit_way, inv_way, wr_way;
    logic                          ent_we;

    wire unused_cmd_lsb = ^cmd_vaddr[11:0];

    function automatic logic ent_match(input logic [63:0] e, input logic v,
                                       input logic [19:0] vpn, input logic [ASID_W-1:0] asid);
        return v && (e[63:44] == vpn) && (e[4] || (e[32 +: ASID_W] == asid));
    endfunction

    assign lk_ready = (state_q == IDLE) && !cmd_valid;
    assign cmd_ready = (state_q == IDLE);
    assign lk_acc   = lk_valid && lk_ready;
    assign cmd_acc  = cmd_valid && cmd_ready;
    assign lk_idx   = lk_vaddr[12 +: IDXW];
    assign cmd_idx  = cmd_vaddr[12 +: IDXW];

    always_comb begin
        lk_hit = 1'b0;
        lk_ent = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && ent_match(ent_q[lk_idx][w], valid_q[lk_idx][w], lk_vaddr[31:12], cur_asid)) begin
                lk_hit = 1'b1;
                lk_ent = ent_q[lk_idx][w];
            end
        end
    end

    always_comb begin
        rs_valid_d = lk_acc;
        rs_paddr_d = rs_paddr_q;
        rs_miss_d  = rs_miss_q;
        rs_prot_d  = rs_prot_q;
        rs_nc_d    = rs_nc_q;
        if (lk_acc) begin
            if (!enable) begin
                rs_paddr_d = lk_vaddr;
                rs_miss_d  = 1'b0;
                rs_prot_d  = 1'b0;
                rs_nc_d    = 1'b0;
            end else if (!lk_hit) begin
                rs_paddr_d = '0;
                rs_miss_d  = 1'b1;
                rs_prot_d  = 1'b0;
                rs_nc_d    = 1'b0;
            end else begin
                rs_paddr_d = {lk_ent[24:5], lk_vaddr[11:0]};
                rs_miss_d  = 1'b0;
                rs_prot_d  = (lk_write && !lk_ent[1]) || (!kmode && lk_ent[2]);
                rs_nc_d    = lk_ent[3];
            end
        end
    end

    // Victim choice: matching way, else lowest invalid way, else round-robin
    always_comb begin
        cmd_hit   = 1'b0;
        cmd_ent   = '0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!cmd_hit && ent_match(ent_q[cmd_idx][w], valid_q[cmd_idx][w], cmd_vaddr[31:12], cmd_asid)) begin
                cmd_hit = 1'b1;
                cmd_ent = ent_q[cmd_idx][w];
                hit_way = RRW'(w);
            end
            if (!inv_found && !valid_q[cmd_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = RRW'(w);
            end
        end
        if (cmd_hit)        wr_way = hit_way;
        else if (inv_found) wr_way = inv_way;
        else                wr_way = rr_q[cmd_idx];
    end

    always_comb begin
        valid_d      = valid_q;
        rr_d         = rr_q;
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        sweep_all_d  = sweep_all_q;
        sweep_asid_d = sweep_asid_q;
        ent_we       = 1'b0;
        rd_valid_d   = 1'b0;
        rd_entry_d   = rd_entry_q;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            ent_we = 1'b1;
                            valid_d[cmd_idx][wr_way] = cmd_entry[0];
                            if (!cmd_hit && !inv_found)
                                rr_d[cmd_idx] = (rr_q[cmd_idx] == RRW'(WAYS - 1)) ? '0 : rr_q[cmd_idx] + 1'b1;
                        end
                        OP_READ: begin
                            rd_valid_d = 1'b1;
                            rd_entry_d = cmd_hit ? {cmd_ent[63:1], 1'b1} : '0;
                        end
                        default: begin
                            state_d      = SWEEP;
                            sweep_idx_d  = '0;
                            sweep_all_d  = (cmd_op == OP_INV_ALL);
                            sweep_asid_d = cmd_asid;
                        end
                    endcase
                end
            end
            SWEEP: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (sweep_all_q || (!ent_q[sweep_idx_q][w][4] &&
                                        ent_q[sweep_idx_q][w][32 +: ASID_W] == sweep_asid_q))
                        valid_d[sweep_idx_q][w] = 1'b0;
                end
                if (sweep_idx_q == IDXW'(SETS - 1)) state_d = IDLE;
                else                                sweep_idx_d = sweep_idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ent_we) ent_q[cmd_idx][wr_way] <= cmd_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            rr_q         <= '0;
            state_q      <= IDLE;
            sweep_idx_q  <= '0;
            sweep_all_q  <= 1'b0;
            sweep_asid_q <= '0;
            rs_valid_q   <= 1'b0;
            rs_paddr_q   <= '0;
            rs_miss_q    <= 1'b0;
            rs_prot_q    <= 1'b0;
            rs_nc_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_entry_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            sweep_all_q  <= sweep_all_d;
            sweep_asid_q <= sweep_asid_d;
            rs_valid_q   <= rs_valid_d;
            rs_paddr_q   <= rs_paddr_d;
            rs_miss_q    <= rs_miss_d;
            rs_prot_q    <= rs_prot_d;
            rs_nc_q      <= rs_nc_d;
            rd_valid_q   <= rd_valid_d;
            rd_entry_q   <= rd_entry_d;
        end
    end

    assign rs_valid = rs_valid_q;
    assign rs_paddr = rs_paddr_q;
    assign rs_miss  = rs_miss_q;
    assign rs_prot  = rs_prot_q;
    assign rs_nc    = rs_nc_q;
    assign rd_valid = rd_valid_q;
    assign rd_entry = rd_entry_q;

`ifdef L2K_TLB_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;

    always_comb begin
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        if (lk_acc && enable) begin
            if (lk_hit && perf_hits_q != 32'hFFFF_FFFF)
                perf_hits_d = perf_hits_q + 32'd1;
            if (!lk_hit && perf_misses_q != 32'hFFFF_FFFF)
                perf_misses_d = perf_misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_l2k_tlb_sa.sv
// Directed bench for l2k_tlb_sa at default parameters (SETS=64, WAYS=2, ASID_W=12).
module tb_l2k_tlb_sa;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        kmode;
    logic [11:0] cur_asid;
    logic        lk_valid;
    logic        lk_ready;
    logic [31:0] lk_vaddr;
    logic        lk_write;
    logic        rs_valid;
    logic [31:0] rs_paddr;
    logic        rs_miss;
    logic        rs_prot;
    logic        rs_nc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_vaddr;
    logic [11:0] cmd_asid;
    logic [63:0] cmd_entry;
    logic        rd_valid;
    logic [63:0] rd_entry;
`ifdef L2K_TLB_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int checks = 0;
    int fails  = 0;
    int n;

    l2k_tlb_sa dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .kmode     (kmode),
        .cur_asid  (cur_asid),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_vaddr  (lk_vaddr),
        .lk_write  (lk_write),
        .rs_valid  (rs_valid),
        .rs_paddr  (rs_paddr),
        .rs_miss   (rs_miss),
        .rs_prot   (rs_prot),
        .rs_nc     (rs_nc),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_vaddr (cmd_vaddr),
        .cmd_asid  (cmd_asid),
        .cmd_entry (cmd_entry),
        .rd_valid  (rd_valid),
        .rd_entry  (rd_entry)
`ifdef L2K_TLB_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [19:0] vpn, input logic [11:0] asid,
                                       input logic [19:0] ppn, input logic g, input logic nc,
                                       input logic k, input logic w, input logic v);
        return {vpn, asid, 7'd0, ppn, g, nc, k, w, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] va, input logic [11:0] asid,
                          input logic wr, input logic km, input logic en);
        lk_valid = 1'b1;
        lk_vaddr = va;
        cur_asid = asid;
        lk_write = wr;
        kmode    = km;
        enable   = en;
        tick();
        lk_valid = 1'b0;
        chk("rs_valid", {63'd0, rs_valid}, 64'd1);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] va,
                       input logic [11:0] asid, input logic [63:0] ent);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_vaddr = va;
        cmd_asid  = asid;
        cmd_entry = ent;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (!cmd_ready && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; kmode = 1'b0; cur_asid = '0;
        lk_valid = 1'b0; lk_vaddr = '0; lk_write = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_vaddr = '0; cmd_asid = '0; cmd_entry = '0;
        tick(); tick();
        chk("reset_rs_valid", {63'd0, rs_valid}, 64'd0);
        chk("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("reset_lk_ready", {63'd0, lk_ready}, 64'd1);
        chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        rst = 1'b1;
        tick();

        // Empty TLB misses; result is a single-cycle pulse
        lookup(32'h0000_5123, 12'd0, 1'b0, 1'b0, 1'b1);
        chk("empty_miss", {63'd0, rs_miss}, 64'd1);
        chk("empty_paddr", {32'd0, rs_paddr}, 64'd0);
        tick();
        chk("rs_pulse_end", {63'd0, rs_valid}, 64'd0);

        // Basic write and ASID-qualified hit
        cmd(2'd0, 32'h0000_5000, 12'd3, mk(20'h00005, 12'd3, 20'h0ABCD, 0, 0, 0, 1, 1));
        lookup(32'h0000_5123, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("hit_paddr", {32'd0, rs_paddr}, 64'h0ABC_D123);
        chk("hit_miss", {63'd0, rs_miss}, 64'd0);
        chk("hit_prot", {63'd0, rs_prot}, 64'd0);
        lookup(32'h0000_5123, 12'd4, 1'b0, 1'b0, 1'b1);
        chk("asid_miss", {63'd0, rs_miss}, 64'd1);
        lookup(32'h0000_5123, 12'd3, 1'b1, 1'b0, 1'b1);
        chk("store_w_prot", {63'd0, rs_prot}, 64'd0);
        lookup(32'h1234_5678, 12'd3, 1'b0, 1'b0, 1'b0);
        chk("ident_paddr", {32'd0, rs_paddr}, 64'h1234_5678);
        chk("ident_miss", {63'd0, rs_miss}, 64'd0);

        // Command beats a simultaneous lookup
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_vaddr = 32'h0000_5000; cmd_asid = 12'd3;
        lk_valid = 1'b1; lk_vaddr = 32'h0000_5123; cur_asid = 12'd3; enable = 1'b1;
        lk_write = 1'b0; kmode = 1'b0;
        #1;
        chk("prio_lk_ready", {63'd0, lk_ready}, 64'd0);
        chk("prio_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("read_valid", {63'd0, rd_valid}, 64'd1);
        chk("read_entry", rd_entry, mk(20'h00005, 12'd3, 20'h0ABCD, 0, 0, 0, 1, 1));
        chk("prio_rs_idle", {63'd0, rs_valid}, 64'd0);
        tick();
        lk_valid = 1'b0;
        chk("late_rs_valid", {63'd0, rs_valid}, 64'd1);
        chk("late_paddr", {32'd0, rs_paddr}, 64'h0ABC_D123);
        chk("rd_pulse_end", {63'd0, rd_valid}, 64'd0);

        // Three VPNs into set 0: the first is evicted round-robin
        cmd(2'd0, 32'h0004_0000, 12'd3, mk(20'h00040, 12'd3, 20'h11111, 0, 0, 0, 1, 1));
        cmd(2'd0, 32'h0008_0000, 12'd3, mk(20'h00080, 12'd3, 20'h22222, 0, 0, 0, 1, 1));
        cmd(2'd0, 32'h000C_0000, 12'd3, mk(20'h000C0, 12'd3, 20'h33333, 0, 0, 0, 1, 1));
        lookup(32'h0004_0000, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("evicted_miss", {63'd0, rs_miss}, 64'd1);
        lookup(32'h0008_0ABC, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("way1_paddr", {32'd0, rs_paddr}, 64'h2222_2ABC);
        lookup(32'h000C_0001, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("way0_paddr", {32'd0, rs_paddr}, 64'h3333_3001);
        // Rewriting a present VPN must overwrite in place, not evict the RR victim
        cmd(2'd0, 32'h000C_0000, 12'd3, mk(20'h000C0, 12'd3, 20'h3CCCC, 0, 1, 0, 1, 1));
        lookup(32'h0008_0ABC, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("keep_way1", {32'd0, rs_paddr}, 64'h2222_2ABC);
        lookup(32'h000C_0001, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("rewrite_paddr", {32'd0, rs_paddr}, 64'h3CCC_C001);
        chk("rewrite_nc", {63'd0, rs_nc}, 64'd1);

        // Permission checks on a kernel read-only page
        cmd(2'd0, 32'h0000_7000, 12'd3, mk(20'h00007, 12'd3, 20'h44444, 0, 0, 1, 0, 1));
        lookup(32'h0000_7FFF, 12'd3, 1'b1, 1'b0, 1'b1);
        chk("user_store_prot", {63'd0, rs_prot}, 64'd1);
        chk("user_store_miss", {63'd0, rs_miss}, 64'd0);
        chk("user_store_paddr", {32'd0, rs_paddr}, 64'h4444_4FFF);
        lookup(32'h0000_7FFF, 12'd3, 1'b0, 1'b1, 1'b1);
        chk("kern_load_prot", {63'd0, rs_prot}, 64'd0);
        lookup(32'h0000_7FFF, 12'd3, 1'b1, 1'b1, 1'b1);
        chk("kern_store_prot", {63'd0, rs_prot}, 64'd1);
        lookup(32'h0000_7FFF, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("user_load_prot", {63'd0, rs_prot}, 64'd1);

        // INV_ASID keeps global entries
        cmd(2'd0, 32'h0000_9000, 12'd5, mk(20'h00009, 12'd5, 20'h55555, 1, 0, 0, 1, 1));
        cmd(2'd3, 32'h0, 12'd3, 64'd0);
        chk("sweep_lk_ready", {63'd0, lk_ready}, 64'd0);
        wait_sweep(n);
        chk("inv_asid_cycles", 64'(n), 64'd64);
        lookup(32'h0000_9000, 12'd0, 1'b0, 1'b0, 1'b1);
        chk("global_hit_miss", {63'd0, rs_miss}, 64'd0);
        chk("global_hit_paddr", {32'd0, rs_paddr}, 64'h5555_5000);
        lookup(32'h0000_5123, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("nong_inv_miss", {63'd0, rs_miss}, 64'd1);
        lookup(32'h0008_0000, 12'd3, 1'b0, 1'b0, 1'b1);
        chk("set0_inv_miss", {63'd0, rs_miss}, 64'd1);
        cmd(2'd2, 32'h0, 12'd0, 64'd0);
        wait_sweep(n);
        chk("inv_all_cycles", 64'(n), 64'd64);
        lookup(32'h0000_9000, 12'd0, 1'b0, 1'b0, 1'b1);
        chk("inv_all_global_miss", {63'd0, rs_miss}, 64'd1);

        // Reset aborts a sweep before it reaches set 5
        cmd(2'd0, 32'h0000_5000, 12'd3, mk(20'h00005, 12'd3, 20'h0ABCD, 0, 0, 0, 1, 1));
        cmd(2'd2, 32'h0, 12'd0, 64'd0);
        tick(); tick(); tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_lk_ready", {63'd0, lk_ready}, 64'd1);
        chk("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("abort_rs_valid", {63'd0, rs_valid}, 64'd0);
        tick();
        chk("abort_rd_valid", {63'd0, rd_valid}, 64'd0);
        cmd(2'd1, 32'h0000_5000, 12'd3, 64'd0);
        chk("abort_read_valid", {63'd0, rd_valid}, 64'd1);
        chk("abort_read_entry", rd_entry, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
